clock_divider_prog: RTL and testbench

Multi-channel programmable clock-enable generator. It replaces fixed power-of-two division taps with per-channel runtime-loadable divisors. Each channel produces a one-cycle `Tick` enable and a 50% duty `ClkOut` square wave. It sits between the board master clock and slow consumers such as keypad scan, display multiplexing and lockout timers. Divisor updates are glitch-free: a new divisor takes effect only at the channel's next terminal count.

---
 rtl/clock_divider_prog.sv | 115 +++++++++++
 tb/tb_clock_divider_prog.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_prog.sv
// clock_divider_prog: multi-channel programmable clock-enable generator.
// Each channel counts master-clock cycles up to a runtime-loadable divisor and
// emits a one-cycle Tick plus a 50% duty ClkOut square wave. New divisors are
// staged in a per-channel holding register and only take effect at the
// channel's next terminal count, so outputs never glitch mid-period.
// Optional feature: define CLKDIV_SYNC_EN to add the Sync phase-align input.
module clock_divider_prog #(
  parameter int NCH      = 2,
  parameter int WIDTH    = 19,
  parameter int DIV_INIT = 262144,
  localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             mClk,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             LdValid,
  input  logic [CW-1:0]    LdChan,
  input  logic [WIDTH-1:0] LdDiv,
  output logic             LdReady,
  output logic [NCH-1:0]   Tick,
  output logic [NCH-1:0]   ClkOut,
  output logic [NCH-1:0]   Pending
`ifdef CLKDIV_SYNC_EN
  ,
  input  logic             Sync
`endif
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DIV_INIT);

  logic [WIDTH-1:0] cnt  [NCH];
  logic [WIDTH-1:0] div  [NCH];
  logic [WIDTH-1:0] pend [NCH];
  logic [NCH-1:0]   ld_sel;
  logic             sync_pulse;

`ifdef CLKDIV_SYNC_EN
  assign sync_pulse = Sync;
`else
  assign sync_pulse = 1'b0;
`endif

  // Ready when the addressed channel exists and has no load already staged.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and a latch is never inferred.
    LdReady = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (LdChan == CW'(i) && !Pending[i]) LdReady = 1'b1;
    end
  end

  // One-hot select of the channel whose load is accepted this cycle.
  always_comb begin
    ld_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      ld_sel[i] = LdValid && LdReady && (LdChan == CW'(i));
    end
  end

  // Per-channel counter, divisor staging and Tick/ClkOut generation.
  always_ff @(posedge mClk) begin
    if (Reset) begin
      // NOTE: cnt/div/pend are a handful of per-channel flops, not a RAM, so
      // they are reset explicitly like any other state.
      for (int i = 0; i < NCH; i++) begin
        cnt[i]     <= '0;
        div[i]     <= DIV_RST;
        pend[i]    <= '0;
        Pending[i] <= 1'b0;
        Tick[i]    <= 1'b0;
        ClkOut[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (sync_pulse || div[i] == '0) begin
          // Channel off or phase-align: park at zero and pick up any staged
          // divisor immediately, then restart counting from cnt=0.
          // NOTE: sequential state uses non-blocking assignments so every
          // channel sees pre-edge values regardless of statement order.
          cnt[i]    <= '0;
          Tick[i]   <= 1'b0;
          ClkOut[i] <= 1'b0;
          if (Pending[i]) begin
            div[i]     <= pend[i];
            Pending[i] <= 1'b0;
          end
        end else if (Enable) begin
          if (cnt[i] == div[i] - WIDTH'(1)) begin
            cnt[i]    <= '0;
            Tick[i]   <= 1'b1;
            ClkOut[i] <= ~ClkOut[i];
            if (Pending[i]) begin
              div[i]     <= pend[i];
              Pending[i] <= 1'b0;
            end
          end else begin
            cnt[i]  <= cnt[i] + WIDTH'(1);
            Tick[i] <= 1'b0;
          end
        end else begin
          Tick[i] <= 1'b0;
        end

        // A load can only be accepted while nothing is staged, so it never
        // collides with the apply paths above.
        if (ld_sel[i]) begin
          pend[i]    <= LdDiv;
          Pending[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Testbench for clock_divider_prog: directed scenarios plus a randomized run,
// all compared against a countdown-style behavioural model of each channel.
`timescale 1ns/1ps
module tb_clock_divider_prog;

  localparam int NCH      = 2;
  localparam int WIDTH    = 8;
  localparam int DIV_INIT = 4;
  localparam int CW       = 1;

  logic             mClk    = 1'b0;
  logic             Reset   = 1'b1;
  logic             Enable  = 1'b0;
  logic             LdValid = 1'b0;
  logic [CW-1:0]    LdChan  = '0;
  logic [WIDTH-1:0] LdDiv   = '0;
  logic             LdReady;
  logic [NCH-1:0]   Tick;
  logic [NCH-1:0]   ClkOut;
  logic [NCH-1:0]   Pending;
  logic             sync_drv = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: edges remaining until the next tick, active divisor,
  // staged divisor, and the expected registered outputs.
  int             m_rem  [NCH];
  int             m_div  [NCH];
  int             m_pend [NCH];
  logic [NCH-1:0] m_tick    = '0;
  logic [NCH-1:0] m_clk     = '0;
  logic [NCH-1:0] m_pending = '0;

  always #5 mClk = ~mClk;

  clock_divider_prog #(
    .NCH(NCH), .WIDTH(WIDTH), .DIV_INIT(DIV_INIT)
  ) dut (
    .mClk(mClk),
    .Reset(Reset),
    .Enable(Enable),
    .LdValid(LdValid),
    .LdChan(LdChan),
    .LdDiv(LdDiv),
    .LdReady(LdReady),
    .Tick(Tick),
    .ClkOut(ClkOut),
    .Pending(Pending)
`ifdef CLKDIV_SYNC_EN
    ,
    .Sync(sync_drv)
`endif
  );

  function automatic logic model_ready();
    return (int'(LdChan) < NCH) && !m_pending[LdChan];
  endfunction

  // Advance the model by one rising edge using the inputs currently driven.
  function automatic void model_edge();
    logic acc;
    acc = LdValid && model_ready();
    for (int ch = 0; ch < NCH; ch++) begin
      if (Reset) begin
        m_div[ch] = DIV_INIT; m_rem[ch] = DIV_INIT; m_pend[ch] = 0;
        m_pending[ch] = 1'b0; m_tick[ch] = 1'b0; m_clk[ch] = 1'b0;
        continue;
      end
      if (sync_drv || m_div[ch] == 0) begin
        m_tick[ch] = 1'b0;
        m_clk[ch]  = 1'b0;
        if (m_pending[ch]) begin
          m_div[ch] = m_pend[ch];
          m_pending[ch] = 1'b0;
        end
        m_rem[ch] = m_div[ch];
      end else if (Enable) begin
        m_rem[ch] = m_rem[ch] - 1;
        if (m_rem[ch] == 0) begin
          m_tick[ch] = 1'b1;
          m_clk[ch]  = ~m_clk[ch];
          if (m_pending[ch]) begin
            m_div[ch] = m_pend[ch];
            m_pending[ch] = 1'b0;
          end
          m_rem[ch] = m_div[ch];
        end else begin
          m_tick[ch] = 1'b0;
        end
      end else begin
        m_tick[ch] = 1'b0;
      end
      if (acc && int'(LdChan) == ch) begin
        m_pend[ch] = int'(LdDiv);
        m_pending[ch] = 1'b1;
      end
    end
  endfunction

  // One clock: model follows the DUT edge, outputs sampled 1 ns later.
  task automatic step();
    @(posedge mClk);
    model_edge();
    #1;
  endtask

  // Hold reset for one edge, release it; the next edge is cycle 1.
  task automatic apply_reset();
    Reset = 1'b1; LdValid = 1'b0;
    step();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Enable = 1'b1; LdValid = 1'b0; Reset = 1'b1;
    step(); step();
    n_checks++;
    if ({Tick, ClkOut, Pending} !== 6'b0)
      $display("FAIL reset_outputs: got %b expected %b", {Tick, ClkOut, Pending}, 6'b0);
    for (int ch = 0; ch < NCH; ch++) begin
      LdChan = CW'(ch); #1;
      n_checks++;
      if (LdReady !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_ready ch%0d: got %b expected 1", ch, LdReady);
      end
    end
    if ({Tick, ClkOut, Pending} !== 6'b0) n_fail++;
    Reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      logic [NCH-1:0] exp_t, exp_c;
      step();
      exp_t = (k % 4 == 0) ? 2'b11 : 2'b00;
      exp_c = ((k / 4) % 2 == 1) ? 2'b11 : 2'b00;
      n_checks++;
      if ({Tick, ClkOut} !== {exp_t, exp_c}) begin
        n_fail++;
        $display("FAIL reset_default_cycle%0d: got tick=%b clk=%b expected tick=%b clk=%b",
                 k, Tick, ClkOut, exp_t, exp_c);
      end
    end
  endtask

  task automatic test_load_while_counting();
    Enable = 1'b1;
    apply_reset();
    repeat (6) step();
    LdChan = 1'b1; LdDiv = 8'd3; LdValid = 1'b1; #1;
    n_checks++;
    if (LdReady !== 1'b1) begin
      n_fail++;
      $display("FAIL load_ready_idle: got %b expected 1", LdReady);
    end
    step();  // cycle 7
    n_checks++;
    if (Pending !== 2'b10) begin
      n_fail++;
      $display("FAIL load_pending_c7: got %b expected 10", Pending);
    end
    LdDiv = 8'd7; #1;  // second load to ch1 must be refused
    n_checks++;
    if (LdReady !== 1'b0) begin
      n_fail++;
      $display("FAIL load_ready_busy: got %b expected 0", LdReady);
    end
    step();  // cycle 8: terminal count with old divisor, staged value applied
    LdValid = 1'b0;
    n_checks++;
    if (Tick !== 2'b11 || Pending !== 2'b00) begin
      n_fail++;
      $display("FAIL load_apply_c8: got tick=%b pend=%b expected tick=11 pend=00", Tick, Pending);
    end
    for (int k = 9; k <= 16; k++) begin
      logic [NCH-1:0] exp_t;
      step();
      exp_t = {(k == 11 || k == 14), (k % 4 == 0)};
      n_checks++;
      if (Tick !== exp_t || Pending !== 2'b00) begin
        n_fail++;
        $display("FAIL load_spacing_c%0d: got tick=%b pend=%b expected tick=%b pend=00",
                 k, Tick, Pending, exp_t);
      end
    end
  endtask

  task automatic test_special_divisors();
    Enable = 1'b1;
    apply_reset();
    LdChan = 1'b0; LdDiv = 8'd0; LdValid = 1'b1;
    step();
    LdValid = 1'b0;
    repeat (5) step();
    for (int j = 0; j < 3; j++) begin
      step();
      n_checks++;
      if (Tick[0] !== 1'b0 || ClkOut[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL div0_off j%0d: got tick=%b clk=%b expected 0 0", j, Tick[0], ClkOut[0]);
      end
    end
    LdDiv = 8'd1; LdValid = 1'b1;
    step();  // accepted
    LdValid = 1'b0;
    step();  // applied on the off channel
    for (int j = 0; j < 6; j++) begin
      step();
      n_checks++;
      if (Tick[0] !== 1'b1 || ClkOut[0] !== logic'(j % 2 == 0)) begin
        n_fail++;
        $display("FAIL div1_run j%0d: got tick=%b clk=%b expected tick=1 clk=%b",
                 j, Tick[0], ClkOut[0], logic'(j % 2 == 0));
      end
      n_checks++;
      if ({Tick, ClkOut, Pending} !== {m_tick, m_clk, m_pending}) begin
        n_fail++;
        $display("FAIL div1_model j%0d: got %b expected %b", j,
                 {Tick, ClkOut, Pending}, {m_tick, m_clk, m_pending});
      end
    end
  endtask

  task automatic test_enable_gap();
    Enable = 1'b1;
    apply_reset();
    step(); step();
    Enable = 1'b0;
    for (int k = 3; k <= 7; k++) begin
      step();
      n_checks++;
      if (Tick !== 2'b00 || ClkOut !== 2'b00) begin
        n_fail++;
        $display("FAIL gap_frozen_c%0d: got tick=%b clk=%b expected 00 00", k, Tick, ClkOut);
      end
    end
    Enable = 1'b1;
    step();  // cycle 8
    n_checks++;
    if (Tick !== 2'b00) begin
      n_fail++;
      $display("FAIL gap_c8: got tick=%b expected 00", Tick);
    end
    step();  // cycle 9
    n_checks++;
    if (Tick !== 2'b11 || ClkOut !== 2'b11) begin
      n_fail++;
      $display("FAIL gap_c9: got tick=%b clk=%b expected 11 11", Tick, ClkOut);
    end
  endtask

  task automatic test_reset_mid_pending();
    Enable = 1'b1;
    apply_reset();
    repeat (5) step();  // ClkOut now high
    LdChan = 1'b1; LdDiv = 8'd6; LdValid = 1'b1;
    step();
    LdValid = 1'b0;
    n_checks++;
    if (Pending !== 2'b10) begin
      n_fail++;
      $display("FAIL rmp_pending: got %b expected 10", Pending);
    end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    n_checks++;
    if ({Tick, ClkOut, Pending} !== 6'b0) begin
      n_fail++;
      $display("FAIL rmp_cleared: got %b expected 000000", {Tick, ClkOut, Pending});
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      n_checks++;
      if (Tick !== ((k % 4 == 0) ? 2'b11 : 2'b00)) begin
        n_fail++;
        $display("FAIL rmp_spacing_c%0d: got %b expected %b", k, Tick,
                 (k % 4 == 0) ? 2'b11 : 2'b00);
      end
    end
  endtask

`ifdef CLKDIV_SYNC_EN
  task automatic test_sync();
    Enable = 1'b1;
    apply_reset();
    LdChan = 1'b1; LdDiv = 8'd6; LdValid = 1'b1;
    step();
    LdValid = 1'b0;
    repeat (9) step();
    sync_drv = 1'b1;
    step();
    sync_drv = 1'b0;
    n_checks++;
    if (ClkOut !== 2'b00 || Tick !== 2'b00) begin
      n_fail++;
      $display("FAIL sync_zero: got clk=%b tick=%b expected 00 00", ClkOut, Tick);
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      n_checks++;
      if (Tick !== {(k == 6), (k == 4)}) begin
        n_fail++;
        $display("FAIL sync_align_c%0d: got %b expected %b", k, Tick, {(k == 6), (k == 4)});
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      Reset   = ($urandom_range(0, 299) == 0);
      Enable  = ($urandom_range(0, 7) != 0);
      LdValid = ($urandom_range(0, 3) == 0);
      LdChan  = CW'($urandom_range(0, NCH - 1));
      LdDiv   = ($urandom_range(0, 9) == 0) ? WIDTH'($urandom_range(0, 40))
                                            : WIDTH'($urandom_range(0, 6));
`ifdef CLKDIV_SYNC_EN
      sync_drv = ($urandom_range(0, 199) == 0);
`endif
      #1;
      n_checks++;
      if (LdReady !== model_ready()) begin
        n_fail++;
        $display("FAIL rand_ready n%0d: got %b expected %b", n, LdReady, model_ready());
      end
      step();
      n_checks++;
      if ({Tick, ClkOut, Pending} !== {m_tick, m_clk, m_pending}) begin
        n_fail++;
        $display("FAIL rand_outputs n%0d: got tick=%b clk=%b pend=%b expected tick=%b clk=%b pend=%b",
                 n, Tick, ClkOut, Pending, m_tick, m_clk, m_pending);
      end
    end
    Reset = 1'b0; LdValid = 1'b0; sync_drv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_while_counting();
    test_special_divisors();
    test_enable_gap();
    test_reset_mid_pending();
`ifdef CLKDIV_SYNC_EN
    test_sync();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
